// File: rtl/ring_seq_n_pkg.sv
// Shared constants and width helper for the ring/Johnson phase sequencer.
// No logic, no latency; no backpressure.
package ring_seq_n_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_UP       = 1'b1;
    localparam logic DIR_DOWN     = 1'b0;

    // Step index must reach 2N-1 in Johnson mode.
    function automatic int calc_pw(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/ring_seq_n_phase_dec.sv
// Step index to N-bit phase pattern (one-hot ring or Johnson twisted ring).
// Purely combinational, zero latency; no backpressure.
module phase_dec
    import ring_seq_n_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = calc_pw(N)
) (
    input  logic [PW-1:0] s,
    input  logic          mode,
    output logic [N-1:0]  pattern
);

    always_comb begin
        pattern = '0;
        for (int i = 0; i < N; i++) begin
            if (mode == MODE_RING) begin
                pattern[i] = (int'(s) == i);
            end else if (int'(s) <= N) begin
                pattern[i] = (i < int'(s));
            end else begin
                // Second half of the Johnson cycle: ones drain out from bit 0 upward.
                pattern[i] = (i >= int'(s) - N);
            end
        end
    end

endmodule

// File: rtl/ring_seq_n.sv
// Parametrised one-hot / Johnson step sequencer with load, direction and wrap pulse.
// Q, Pos and Wrap are registered and change on the same edge; no backpressure.
module ring_seq_n
    import ring_seq_n_pkg::*;
#(
    parameter int N         = 4,
    parameter int RESET_POS = 0,
    parameter int PW        = calc_pw(N)
) (
    input  logic          clock,
    input  logic          Reset,
    input  logic          En,
    input  logic          Dir,
    input  logic          Mode,
    input  logic          Load,
    input  logic [PW-1:0] LoadPos,
    output logic [N-1:0]  Q,
    output logic [PW-1:0] Pos,
    output logic          Wrap
);

    localparam logic [PW:0]   M_RING    = (PW + 1)'(N);
    localparam logic [PW:0]   M_JOHNSON = (PW + 1)'(2 * N);
    localparam logic [PW-1:0] S_RESET   = PW'(RESET_POS);

    logic [PW-1:0] s_q, s_d;
    logic          wrap_q, wrap_d;
    logic [N-1:0]  q_q, q_d;
    logic [PW:0]   modulus;
    logic [PW:0]   s_ext;

    assign modulus = (Mode == MODE_JOHNSON) ? M_JOHNSON : M_RING;
    assign s_ext   = {1'b0, s_q};

    always_comb begin
        s_d    = s_q;
        wrap_d = 1'b0;
        if (Reset) begin
            s_d = S_RESET;
        end else if (Load) begin
            s_d = ({1'b0, LoadPos} < modulus) ? LoadPos : '0;
        end else if (s_ext >= modulus) begin
            // Left over from a Johnson->ring switch; snap back into range.
            s_d = '0;
        end else if (En) begin
            if (Dir == DIR_UP) begin
                if (s_ext == modulus - 1'b1) begin
                    s_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    s_d = s_q + 1'b1;
                end
            end else begin
                if (s_q == '0) begin
                    s_d    = PW'(modulus - 1'b1);
                    wrap_d = 1'b1;
                end else begin
                    s_d = s_q - 1'b1;
                end
            end
        end
    end

    // Decoding the next index keeps Q aligned with Pos on every edge.
    phase_dec #(
        .N  (N),
        .PW (PW)
    ) u_phase_dec (
        .s       (s_d),
        .mode    (Mode),
        .pattern (q_d)
    );

    always_ff @(posedge clock) begin
        if (Reset) begin
            s_q    <= S_RESET;
            wrap_q <= 1'b0;
            q_q    <= q_d;
        end else begin
            s_q    <= s_d;
            wrap_q <= wrap_d;
            q_q    <= q_d;
        end
    end

    assign Q    = q_q;
    assign Pos  = s_q;
    assign Wrap = wrap_q;

endmodule
